ghash_ctrl: RTL and testbench

Sequencer for the GCM authentication path. It streams AAD and ciphertext blocks through the shared single-cycle GF(2^128) multiply stage, then issues the final length block and returns the GHASH value. The multiply stage registers its inputs (i1 ^ i2, i3) and presents the product combinationally, so results arrive one cycle after issue. This block sits between the block-stream source and that stage and owns the hash accumulator Y.

---
 rtl/ghash_pkg.sv | 30 +++
 rtl/ghash_ctrl.sv | 131 +++++++++++++
 tb/tb_ghash_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ghash_pkg.sv
// Shared types and helpers for the GHASH sequencer: FSM encoding, block-type
// codes, bit-length counter width and the partial-block byte mask.
package ghash_pkg;

    localparam int LEN_W = 64;

    localparam logic BLK_AAD = 1'b0;
    localparam logic BLK_CT  = 1'b1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WAIT = 3'd1,
        MUL  = 3'd2,
        LEN  = 3'd3,
        LMUL = 3'd4
    } state_t;

    // Byte 0 is the most significant byte; bytes at index >= nbytes are dropped.
    // nbytes == 0 encodes a full 16-byte block.
    function automatic logic [127:0] byte_mask(input logic [3:0] nbytes);
        logic [4:0] n;
        byte_mask = '0;
        n = (nbytes == 4'd0) ? 5'd16 : {1'b0, nbytes};
        for (int i = 0; i < 16; i++) begin
            if (5'(i) < n)
                byte_mask[127 - 8*i -: 8] = 8'hff;
        end
    endfunction

endpackage

// File: rtl/ghash_ctrl.sv
// GHASH sequencer: feeds AAD/ciphertext blocks and the final length block
// through an external single-cycle GF(2^128) multiply stage, owns Y and H.
module ghash_ctrl
    import ghash_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] h,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic [127:0] blk_data,
    input  logic         blk_type,
    input  logic [3:0]   blk_bytes,
    input  logic         fin,
    output logic [127:0] mul_i1,
    output logic [127:0] mul_i2,
    output logic [127:0] mul_i3,
    input  logic [127:0] mul_o,
    output logic [127:0] hash,
    output logic         done,
    output logic         busy,
    output logic         err
);

    state_t             state, state_nxt;
    logic [127:0]       y_q;
    logic [127:0]       h_q;
    logic [LEN_W-1:0]   aad_bits;
    logic [LEN_W-1:0]   ct_bits;
    logic               seen_ct;

    logic               rdy;
    logic               accept;
    logic               ooo;
    logic               issue_blk;
    logic [LEN_W-1:0]   blk_bits;

    // A pending start owns the cycle, so no block may be consumed under it.
    assign rdy       = (state == WAIT) && !start;
    assign accept    = blk_valid && rdy;
    assign ooo       = (blk_type == BLK_AAD) && seen_ct;
    assign issue_blk = accept && !ooo;
    assign blk_bits  = (blk_bytes == 4'd0) ? LEN_W'(128) : LEN_W'({blk_bytes, 3'b000});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: state_nxt = IDLE;
            WAIT: begin
                if (accept) begin
                    if (!ooo)
                        state_nxt = MUL;
                end else if (fin) begin
                    state_nxt = LEN;
                end
            end
            MUL:     state_nxt = WAIT;
            LEN:     state_nxt = LMUL;
            LMUL:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (start)
            state_nxt = WAIT;
    end

    always_comb begin
        blk_ready = rdy;
        busy      = (state != IDLE);
        mul_i1    = '0;
        mul_i2    = '0;
        mul_i3    = '0;
        if (issue_blk) begin
            mul_i1 = y_q;
            mul_i2 = blk_data & byte_mask(blk_bytes);
            mul_i3 = h_q;
        end else if (state == LEN) begin
            mul_i1 = y_q;
            mul_i2 = {aad_bits, ct_bits};
            mul_i3 = h_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q      <= '0;
            h_q      <= '0;
            hash     <= '0;
            aad_bits <= '0;
            ct_bits  <= '0;
            seen_ct  <= 1'b0;
            err      <= 1'b0;
            done     <= 1'b0;
        end else if (start) begin
            // hash is deliberately kept: it holds until the next completed LMUL.
            y_q      <= '0;
            h_q      <= h;
            aad_bits <= '0;
            ct_bits  <= '0;
            seen_ct  <= 1'b0;
            err      <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= (state == LMUL);
            if (accept) begin
                if (ooo) begin
                    err <= 1'b1;
                end else if (blk_type == BLK_CT) begin
                    ct_bits <= ct_bits + blk_bits;
                    seen_ct <= 1'b1;
                end else begin
                    aad_bits <= aad_bits + blk_bits;
                end
            end
            if (state == MUL)
                y_q <= mul_o;
            if (state == LMUL) begin
                y_q  <= mul_o;
                hash <= mul_o;
            end
        end
    end

endmodule

// File: tb/tb_ghash_ctrl.sv
// Randomized scoreboard bench for ghash_ctrl with a behavioural GHASH model
// and a stand-in registered GF(2^128) multiply stage.
module tb_ghash_ctrl;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [127:0] h = '0;
    logic         blk_valid = 1'b0;
    logic         blk_ready;
    logic [127:0] blk_data = '0;
    logic         blk_type = 1'b0;
    logic [3:0]   blk_bytes = '0;
    logic         fin = 1'b0;
    logic [127:0] mul_i1, mul_i2, mul_i3, mul_o, hash;
    logic         done, busy, err;

    always #5 clk = ~clk;

    ghash_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .h(h),
        .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
        .blk_type(blk_type), .blk_bytes(blk_bytes), .fin(fin),
        .mul_i1(mul_i1), .mul_i2(mul_i2), .mul_i3(mul_i3), .mul_o(mul_o),
        .hash(hash), .done(done), .busy(busy), .err(err)
    );

    // GCM field multiply, bit 127 of the vector = first bit of the block.
    function automatic logic [127:0] gmul(input logic [127:0] x, input logic [127:0] y);
        logic [127:0] z, v;
        z = '0;
        v = y;
        for (int i = 0; i < 128; i++) begin
            if (x[127-i]) z = z ^ v;
            v = v[0] ? ((v >> 1) ^ {8'he1, 120'h0}) : (v >> 1);
        end
        return z;
    endfunction

    function automatic logic [127:0] tb_mask(input logic [3:0] nb);
        int n;
        n = (nb == 4'd0) ? 16 : int'(nb);
        return ~128'h0 << (8 * (16 - n));
    endfunction

    logic [127:0] ms_a = '0, ms_b = '0;
    always @(posedge clk) begin
        ms_a <= mul_i1 ^ mul_i2;
        ms_b <= mul_i3;
    end
    assign mul_o = gmul(ms_a, ms_b);

    typedef struct packed { logic [127:0] i1, i2, i3; } op_t;
    op_t          exp_op[$];
    logic [127:0] exp_hash[$];
    int           done_cnt = 0;
    int           hash_pushed = 0;
    int           n_chk = 0;
    int           n_fail = 0;

    logic [127:0] m_h, m_y;
    logic [63:0]  m_aad, m_ct;
    bit           m_seen_ct;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic flag(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    // Monitor: compares every multiply issue and every done pulse to the queues.
    initial begin
        op_t op;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n) begin
                if (mul_i3 != '0) begin
                    if (exp_op.size() == 0) flag("unexpected_issue");
                    else begin
                        op = exp_op.pop_front();
                        check("mul_i1", mul_i1, op.i1);
                        check("mul_i2", mul_i2, op.i2);
                        check("mul_i3", mul_i3, op.i3);
                    end
                end else begin
                    check("idle_operands", mul_i1 | mul_i2, '0);
                end
                if (done) begin
                    done_cnt++;
                    if (exp_hash.size() == 0) flag("unexpected_done");
                    else check("hash", hash, exp_hash.pop_front());
                end
            end
        end
    end

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_push(input logic [127:0] d, input logic t, input logic [3:0] nb);
        if (!(t == 1'b0 && m_seen_ct))
            exp_op.push_back('{m_y, d & tb_mask(nb), m_h});
    endtask

    task automatic model_commit(input logic [127:0] d, input logic t, input logic [3:0] nb);
        int n;
        n = (nb == 4'd0) ? 16 : int'(nb);
        if (!(t == 1'b0 && m_seen_ct)) begin
            m_y = gmul(m_y ^ (d & tb_mask(nb)), m_h);
            if (t) begin
                m_ct = m_ct + 64'(8 * n);
                m_seen_ct = 1'b1;
            end else begin
                m_aad = m_aad + 64'(8 * n);
            end
        end
    endtask

    // All tasks begin and end 1 time unit after a rising edge.
    task automatic do_start(input logic [127:0] hk);
        start = 1'b1;
        h = hk;
        @(posedge clk); #1;
        start = 1'b0;
        m_h = hk; m_y = '0; m_aad = '0; m_ct = '0; m_seen_ct = 1'b0;
    endtask

    task automatic send(input logic [127:0] d, input logic t, input logic [3:0] nb, input int gap);
        int k;
        repeat (gap) begin @(posedge clk); #1; end
        blk_valid = 1'b1; blk_data = d; blk_type = t; blk_bytes = nb;
        model_push(d, t, nb);
        for (k = 0; k < 10; k++) begin
            @(negedge clk);
            if (blk_ready) break;
        end
        if (k == 10) flag("send_timeout");
        @(posedge clk); #1;
        blk_valid = 1'b0;
        if (k < 10) model_commit(d, t, nb);
    endtask

    task automatic do_fin(input bit rst_lmul, output int lat);
        logic [127:0] lb;
        int k;
        lb = {m_aad, m_ct};
        fin = 1'b1;
        exp_op.push_back('{m_y, lb, m_h});
        lat = -1;
        if (!rst_lmul) begin
            exp_hash.push_back(gmul(m_y ^ lb, m_h));
            hash_pushed++;
            for (k = 0; k < 20; k++) begin
                @(negedge clk); #2;
                if (done) break;
            end
            if (k == 20) flag("done_timeout");
            lat = k;
            @(posedge clk); #1;
        end else begin
            for (k = 0; k < 20; k++) begin
                @(negedge clk); #2;
                if (exp_op.size() == 0) break;
            end
            if (k == 20) flag("len_timeout");
            @(posedge clk); #1;
            rst_n = 1'b0;
            @(posedge clk); #1;
            rst_n = 1'b1;
        end
        fin = 1'b0;
    endtask

    task automatic random_msg(input int n_aad, input int n_ct);
        int lat;
        do_start(rnd128() | 128'h1);
        for (int i = 0; i < n_aad; i++)
            send(rnd128(), 1'b0, 4'($urandom_range(0, 15)), $urandom_range(0, 2));
        for (int i = 0; i < n_ct; i++)
            send(rnd128(), 1'b1, 4'($urandom_range(0, 15)), $urandom_range(0, 2));
        do_fin(1'b0, lat);
    endtask

    localparam logic [127:0] H0 = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [127:0] C0 = 128'h0388dace60b6a392f328c2b971b2fe78;

    initial begin
        int lat, acc, d0, idx;
        logic [7:0] pat;
        logic [127:0] sd[4];
        logic rd;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", blk_ready, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_hash", hash, 0);
        check("rst_mul", mul_i1 | mul_i2 | mul_i3, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Empty message: fin already high when start lands
        fin = 1'b1;
        do_start(H0);
        check("wait_busy", busy, 1);
        do_fin(1'b0, lat);
        check("empty_latency", lat, 3);
        check("empty_hash", hash, 0);
        check("idle_busy", busy, 0);

        // Single ciphertext block, known GCM vector
        do_start(H0);
        send(C0, 1'b1, 4'd0, 0);
        do_fin(1'b0, lat);
        check("tc2_hash", hash, 128'hf38cbb1ad69223dcc3457ae5b6b0f885);

        // Partial 5-byte block with garbage in the tail
        do_start(rnd128() | 128'h1);
        send(rnd128() | 128'h1, 1'b1, 4'd5, 1);
        do_fin(1'b0, lat);

        // Ordering violation: AAD, CT, AAD
        do_start(rnd128() | 128'h1);
        send(rnd128(), 1'b0, 4'd0, 0);
        send(rnd128(), 1'b1, 4'd0, 0);
        check("err_before", err, 0);
        send(rnd128(), 1'b0, 4'd0, 0);
        check("err_after", err, 1);
        do_fin(1'b0, lat);
        check("err_sticky", err, 1);
        do_start(rnd128() | 128'h1);
        check("err_cleared", err, 0);

        // Back-pressure: valid held for four full ciphertext blocks
        for (int i = 0; i < 4; i++) sd[i] = rnd128();
        idx = 0; acc = 0; pat = '0;
        blk_valid = 1'b1; blk_type = 1'b1; blk_bytes = 4'd0; blk_data = sd[0];
        model_push(sd[0], 1'b1, 4'd0);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            rd = blk_ready;
            pat[7-c] = rd;
            if (rd && idx < 4) acc++;
            @(posedge clk); #1;
            if (rd && idx < 4) begin
                model_commit(sd[idx], 1'b1, 4'd0);
                idx++;
                if (idx < 4) begin
                    blk_data = sd[idx];
                    model_push(sd[idx], 1'b1, 4'd0);
                end else begin
                    blk_valid = 1'b0;
                end
            end
        end
        blk_valid = 1'b0;
        check("bp_ready_pattern", pat, 8'b10101010);
        check("bp_accepts", acc, 4);
        do_fin(1'b0, lat);

        // Abort with start during MUL
        d0 = done_cnt;
        do_start(rnd128() | 128'h1);
        send(rnd128(), 1'b1, 4'd0, 0);
        do_start(rnd128() | 128'h1);
        check("abort_no_done", done_cnt, d0);
        send(rnd128(), 1'b0, 4'd3, 0);
        send(rnd128(), 1'b1, 4'd0, 0);
        do_fin(1'b0, lat);

        // Reset while in LMUL
        d0 = done_cnt;
        do_start(rnd128() | 128'h1);
        send(rnd128(), 1'b1, 4'd0, 0);
        send(rnd128(), 1'b1, 4'd9, 0);
        do_fin(1'b1, lat);
        repeat (4) @(posedge clk);
        #1;
        check("rst_lmul_no_done", done_cnt, d0);
        check("rst_lmul_hash", hash, 0);
        check("rst_lmul_busy", busy, 0);
        random_msg(1, 2);

        // Randomized messages
        for (int m = 0; m < 6; m++)
            random_msg($urandom_range(0, 3), $urandom_range(0, 3));

        repeat (5) @(posedge clk);
        #1;
        check("ops_drained", exp_op.size(), 0);
        check("hashes_drained", exp_hash.size(), 0);
        check("done_count", done_cnt, hash_pushed);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

endmodule
